// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA engines.
//  AXI_BURST_INCR / AXI_RESP_OKAY : AXI encodings used on the AR and R channels
//  AXI_MAX_BURST                  : longest INCR burst in beats
//  dma_cmd_t                      : {addr,len} command at the default widths
//  rd_state_e                     : read engine FSM states
package dma_pkg;

   localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
   localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
   localparam int unsigned AXI_MAX_BURST  = 256;

   localparam int unsigned DMA_ADDR_WIDTH = 32;
   localparam int unsigned DMA_LEN_WIDTH  = 9;

   typedef struct packed {
      logic [DMA_ADDR_WIDTH-1:0] addr;
      logic [DMA_LEN_WIDTH-1:0]  len;
   } dma_cmd_t;

   typedef enum logic [1:0] {IDLE, ADDR, DATA} rd_state_e;

endpackage

// File: rtl/dma_cmd_fifo.sv
// Small synchronous first-word-fall-through command FIFO.
//  clk, rst_n : clock, asynchronous active-low reset (pointers and count only)
//  push/wdata : write request, ignored when full
//  pop/rdata  : read request, ignored when empty; rdata always shows the head entry
//  full/empty : occupancy flags from the registered count
//  count      : number of stored entries
module dma_cmd_fifo #(
   parameter int unsigned WIDTH = 41,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/dma_read_engine.sv
// DMA read engine: queues {addr,len} commands, issues one AXI4 INCR read burst per
// command (one outstanding) and streams returned beats to the datapath.
//  config_valid/ready/len/addr : command push;  config_empty : no queued or active work
//  m_axi_ar*                   : AR channel master;  m_axi_r*  : R channel
//  out_data/valid/ready/last   : beat stream, out_last marks the last beat of a command
//  err_resp/err_last/err_clear : sticky bad-response and rlast-mismatch flags
module dma_read_engine
   import dma_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH   = DMA_ADDR_WIDTH,
   parameter int unsigned AXI_DATA_WIDTH   = 64,
   parameter int unsigned CONFIG_LEN_WIDTH = DMA_LEN_WIDTH,
   parameter int unsigned CMD_DEPTH        = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        config_valid,
   output logic                        config_ready,
   output logic                        config_empty,
   input  logic [CONFIG_LEN_WIDTH-1:0] config_len,
   input  logic [AXI_ADDR_WIDTH-1:0]   config_addr,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]                  m_axi_arlen,
   output logic [2:0]                  m_axi_arsize,
   output logic [1:0]                  m_axi_arburst,
   output logic                        m_axi_arvalid,
   input  logic                        m_axi_arready,
   input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                  m_axi_rresp,
   input  logic                        m_axi_rlast,
   input  logic                        m_axi_rvalid,
   output logic                        m_axi_rready,
   output logic [AXI_DATA_WIDTH-1:0]   out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic                        err_resp,
   output logic                        err_last,
   input  logic                        err_clear
);

   localparam int unsigned CMD_WIDTH = AXI_ADDR_WIDTH + CONFIG_LEN_WIDTH;
   localparam logic [2:0]  ARSIZE    = 3'($clog2(AXI_DATA_WIDTH / 8));
   localparam logic [CONFIG_LEN_WIDTH-1:0] LEN_ONE = CONFIG_LEN_WIDTH'(1);
   localparam logic [CONFIG_LEN_WIDTH-1:0] LEN_MAX = CONFIG_LEN_WIDTH'(AXI_MAX_BURST);

   rd_state_e                   state_q;
   logic [AXI_ADDR_WIDTH-1:0]   araddr_q;
   logic [7:0]                  arlen_q;
   logic                        arvalid_q;
   logic [CONFIG_LEN_WIDTH-1:0] beat_cnt_q;
   logic                        err_resp_q, err_last_q;

   logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CMD_WIDTH-1:0]        fifo_head;
   logic [$clog2(CMD_DEPTH):0]  fifo_count;
   logic [AXI_ADDR_WIDTH-1:0]   head_addr;
   logic [CONFIG_LEN_WIDTH-1:0] head_len, head_len_sat;
   logic                        head_ok, load, beat, final_beat;

   dma_cmd_fifo #(
      .WIDTH (CMD_WIDTH),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata ({config_addr, config_len}),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign head_addr    = fifo_head[CMD_WIDTH-1 -: AXI_ADDR_WIDTH];
   assign head_len     = fifo_head[CONFIG_LEN_WIDTH-1:0];
   // Oversized lengths are illegal; clamp so the burst stays a legal 256 beats.
   assign head_len_sat = (head_len > LEN_MAX) ? LEN_MAX : head_len;
   assign head_ok      = ~fifo_empty & (head_len != '0);

   assign beat       = (state_q == DATA) & m_axi_rvalid & out_ready;
   assign final_beat = beat & (beat_cnt_q == LEN_ONE);

   // ready comes from the registered count; full gates the push itself.
   assign config_ready = (32'(fifo_count) < CMD_DEPTH);
   assign fifo_push    = config_valid & ~fifo_full;
   // IDLE pops every head, discarding zero-length commands; the final beat of a burst
   // pops a real command so the next AR follows with no idle cycle.
   assign fifo_pop     = ((state_q == IDLE) & ~fifo_empty) | (final_beat & head_ok);
   assign load         = fifo_pop & (head_len != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arvalid_q  <= 1'b0;
         beat_cnt_q <= '0;
         err_resp_q <= 1'b0;
         err_last_q <= 1'b0;
      end else begin
         // Clear first so a new error in the same cycle wins.
         if (err_clear) begin
            err_resp_q <= 1'b0;
            err_last_q <= 1'b0;
         end
         if (beat && (m_axi_rresp != AXI_RESP_OKAY)) err_resp_q <= 1'b1;
         if (beat && (m_axi_rlast != (beat_cnt_q == LEN_ONE))) err_last_q <= 1'b1;

         unique case (state_q)
            IDLE: ;
            ADDR: begin
               if (m_axi_arready) begin
                  arvalid_q <= 1'b0;
                  state_q   <= DATA;
               end
            end
            DATA: begin
               if (beat) begin
                  beat_cnt_q <= beat_cnt_q - LEN_ONE;
                  if (final_beat) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         // Placed last so a back-to-back reload overrides the DATA updates above.
         if (load) begin
            araddr_q   <= head_addr;
            arlen_q    <= 8'(head_len_sat - LEN_ONE);
            beat_cnt_q <= head_len_sat;
            arvalid_q  <= 1'b1;
            state_q    <= ADDR;
         end
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n && fifo_pop) assert (head_len <= LEN_MAX);
   end
`endif

   assign config_empty  = fifo_empty & (state_q == IDLE);
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_arsize  = ARSIZE;
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = (state_q == DATA) & out_ready;
   assign out_valid     = (state_q == DATA) & m_axi_rvalid;
   assign out_data     = (state_q == DATA) ? m_axi_rdata : '0;
   assign out_last      = (state_q == DATA) & (beat_cnt_q == LEN_ONE);
   assign err_resp      = err_resp_q;
   assign err_last      = err_last_q;

endmodule

// File: tb/tb_dma_read_engine.sv
module tb_dma_read_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        config_valid, config_ready, config_empty;
   logic [8:0]  config_len;
   logic [31:0] config_addr;
   logic [31:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic        m_axi_arvalid, m_axi_arready;
   logic [63:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
   logic [63:0] out_data;
   logic        out_valid, out_ready, out_last;
   logic        err_resp, err_last, err_clear;

   dma_read_engine dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .config_valid  (config_valid),
      .config_ready  (config_ready),
      .config_empty  (config_empty),
      .config_len    (config_len),
      .config_addr   (config_addr),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arsize  (m_axi_arsize),
      .m_axi_arburst (m_axi_arburst),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rlast   (m_axi_rlast),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_last      (out_last),
      .err_resp      (err_resp),
      .err_last      (err_last),
      .err_clear     (err_clear)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Reference model: expected AR {addr,arlen} and expected beats {data,last}.
   logic [39:0] exp_ar_q[$];
   logic [64:0] exp_beat_q[$];
   int          fin_q[$];
   int          ar_rise_q[$];
   logic        fin_empty_val;
   int          n_beats, n_ar, n_arvalid_cyc;

   // Slave / sink knobs.
   int   ar_stall        = 0;
   int   rlast_fault_idx = -1;
   int   resp_fault_idx  = -1;
   logic r_rand          = 1'b0;
   logic rand_ready      = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] beat_data(input logic [31:0] a, input int i);
      logic [31:0] lo;
      lo = a + 32'(i * 8);
      return {lo, ~lo ^ 32'h5a5a_0000};
   endfunction

   function automatic void model_push(input logic [31:0] a, input logic [8:0] l);
      if (l != 9'd0) begin
         exp_ar_q.push_back({a, 8'(l - 9'd1)});
         for (int i = 0; i < int'(l); i++)
            exp_beat_q.push_back({beat_data(a, i), i == int'(l) - 1});
      end
   endfunction

   task automatic clear_trace();
      fin_q.delete();
      ar_rise_q.delete();
      n_beats = 0;
      n_ar = 0;
      n_arvalid_cyc = 0;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic push_cmd(input logic [31:0] a, input logic [8:0] l);
      int t = 0;
      config_valid = 1'b1;
      config_addr  = a;
      config_len   = l;
      @(negedge clk);
      while (!config_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("push_accept", 64'(config_ready), 64'd1);
      if (config_ready) model_push(a, l);
      @(posedge clk);
      #1;
      config_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int t = 0;
      while ((exp_beat_q.size() + exp_ar_q.size()) != 0 && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("drain", 64'(exp_beat_q.size() + exp_ar_q.size()), 64'd0);
   endtask

   // AXI read slave.
   initial begin : slave
      int          wait_cnt;
      int          s_len, s_idx;
      logic        act, r_hs;
      logic [31:0] s_addr;
      wait_cnt = 0; s_len = 0; s_idx = 0; act = 1'b0; r_hs = 1'b0; s_addr = '0;
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_rdata   = '0;
      m_axi_rresp   = 2'b00;
      m_axi_rlast   = 1'b0;
      forever begin
         @(negedge clk);
         r_hs = m_axi_rvalid & m_axi_rready;
         if (!rst_n) begin
            act = 1'b0;
            wait_cnt = 0;
            r_hs = 1'b0;
         end else begin
            if (r_hs) begin
               s_idx++;
               if (s_idx == s_len) act = 1'b0;
            end
            if (m_axi_arvalid && m_axi_arready) begin
               act = 1'b1;
               s_addr = m_axi_araddr;
               s_len = int'(m_axi_arlen) + 1;
               s_idx = 0;
               wait_cnt = 0;
            end else if (m_axi_arvalid) begin
               wait_cnt++;
            end
         end
         @(posedge clk);
         #1;
         m_axi_arready = rst_n && (ar_stall == 0 || wait_cnt >= ar_stall);
         if (!rst_n || !act) begin
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
         end else if (!(m_axi_rvalid && !r_hs)) begin
            m_axi_rvalid = r_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi_rdata  = beat_data(s_addr, s_idx);
            m_axi_rlast  = (rlast_fault_idx >= 0) ? (s_idx == rlast_fault_idx)
                                                  : (s_idx == s_len - 1);
            m_axi_rresp  = (s_idx == resp_fault_idx) ? 2'b10 : 2'b00;
         end
      end
   end

   initial begin : sink
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin : monitor
      logic [39:0] ar_exp, ar_prev;
      logic [64:0] b_exp;
      logic        arvalid_prev, arready_prev;
      ar_prev = '0; arvalid_prev = 1'b0; arready_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            arvalid_prev = 1'b0;
            arready_prev = 1'b0;
         end else begin
            if (m_axi_arvalid) n_arvalid_cyc++;
            if (m_axi_arvalid && !arvalid_prev) ar_rise_q.push_back(cyc);
            if (m_axi_arvalid && arvalid_prev && !arready_prev)
               check("ar_stable", 64'({m_axi_araddr, m_axi_arlen}), 64'(ar_prev));
            if (m_axi_arvalid && m_axi_arready) begin
               n_ar++;
               check("ar_expected", 64'(exp_ar_q.size() != 0), 64'd1);
               if (exp_ar_q.size() != 0) begin
                  ar_exp = exp_ar_q.pop_front();
                  check("araddr", 64'(m_axi_araddr), 64'(ar_exp[39:8]));
                  check("arlen", 64'(m_axi_arlen), 64'(ar_exp[7:0]));
               end
            end
            if (out_valid) check("rready_mirror", 64'(m_axi_rready), 64'(out_ready));
            if (out_valid && out_ready) begin
               n_beats++;
               check("beat_expected", 64'(exp_beat_q.size() != 0), 64'd1);
               if (exp_beat_q.size() != 0) begin
                  b_exp = exp_beat_q.pop_front();
                  check("out_data", out_data, b_exp[64:1]);
                  check("out_last", 64'(out_last), 64'(b_exp[0]));
                  if (b_exp[0]) begin
                     fin_q.push_back(cyc);
                     fin_empty_val = config_empty;
                  end
               end
            end
            arvalid_prev = m_axi_arvalid;
            arready_prev = m_axi_arready;
            ar_prev      = {m_axi_araddr, m_axi_arlen};
         end
      end
   end

   initial begin : main
      int total, t;
      logic [31:0] a;
      logic [8:0]  l;
      rst_n = 1'b0;
      config_valid = 1'b0;
      config_len = '0;
      config_addr = '0;
      err_clear = 1'b0;
      clear_trace();

      // Reset values.
      @(negedge clk);
      check("rst_config_ready", 64'(config_ready), 64'd1);
      check("rst_config_empty", 64'(config_empty), 64'd1);
      check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
      check("rst_araddr", 64'(m_axi_araddr), 64'd0);
      check("rst_arlen", 64'(m_axi_arlen), 64'd0);
      check("rst_rready", 64'(m_axi_rready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_errs", 64'({err_resp, err_last}), 64'd0);
      check("arsize", 64'(m_axi_arsize), 64'd3);
      check("arburst", 64'(m_axi_arburst), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 1: single 64-beat burst, everything ready.
      clear_trace();
      push_cmd(32'h1000, 9'd64);
      drain(500);
      check("t1_beats", 64'(n_beats), 64'd64);
      check("t1_ars", 64'(n_ar), 64'd1);
      check("t1_empty_at_final", 64'(fin_empty_val), 64'd0);
      if (fin_q.size() != 0) while (cyc < fin_q[$] + 1) @(negedge clk);
      check("t1_empty_after", 64'(config_empty), 64'd1);
      @(posedge clk);
      #1;

      // 2: back-to-back commands while AR stalls; no bubble between bursts.
      clear_trace();
      ar_stall = 20;
      push_cmd(32'h0001_0000, 9'd64);
      push_cmd(32'h0001_1000, 9'd64);
      push_cmd(32'h0001_2000, 9'd64);
      push_cmd(32'h0001_3000, 9'd10);
      push_cmd(32'h0001_4000, 9'd3);
      @(negedge clk);
      check("t2_ready_full", 64'(config_ready), 64'd0);
      check("t2_not_empty", 64'(config_empty), 64'd0);
      drain(3000);
      ar_stall = 0;
      check("t2_ars", 64'(n_ar), 64'd5);
      check("t2_rises", 64'(ar_rise_q.size()), 64'd5);
      if (ar_rise_q.size() == 5 && fin_q.size() == 5)
         for (int i = 1; i < 5; i++)
            check("t2_no_bubble", 64'(ar_rise_q[i]), 64'(fin_q[i-1] + 1));
      @(posedge clk);
      #1;

      // 3: random addresses/lengths, random rvalid and out_ready.
      clear_trace();
      r_rand = 1'b1;
      rand_ready = 1'b1;
      total = 0;
      for (int i = 0; i < 6; i++) begin
         a = $urandom() & 32'hffff_fff8;
         l = 9'($urandom_range(1, 40));
         total += int'(l);
         push_cmd(a, l);
      end
      drain(5000);
      check("t3_beats", 64'(n_beats), 64'(total));
      r_rand = 1'b0;
      rand_ready = 1'b0;
      @(posedge clk);
      #1;

      // 4: zero-length command is discarded, then a single beat.
      clear_trace();
      push_cmd(32'h3000, 9'd0);
      push_cmd(32'h2000, 9'd1);
      drain(200);
      check("t4_ars", 64'(n_ar), 64'd1);
      check("t4_beats", 64'(n_beats), 64'd1);
      @(negedge clk);
      check("t4_empty", 64'(config_empty), 64'd1);
      @(posedge clk);
      #1;

      // 5: early rlast and SLVERR; beat count still governs.
      clear_trace();
      check("t5_errs_clean", 64'({err_resp, err_last}), 64'd0);
      rlast_fault_idx = 2;
      resp_fault_idx = 1;
      push_cmd(32'h4000, 9'd4);
      drain(200);
      rlast_fault_idx = -1;
      resp_fault_idx = -1;
      check("t5_beats", 64'(n_beats), 64'd4);
      check("t5_err_resp", 64'(err_resp), 64'd1);
      check("t5_err_last", 64'(err_last), 64'd1);
      repeat (5) @(negedge clk);
      check("t5_sticky", 64'({err_resp, err_last}), 64'd3);
      @(posedge clk);
      #1;
      err_clear = 1'b1;
      @(posedge clk);
      #1;
      err_clear = 1'b0;
      @(negedge clk);
      check("t5_cleared", 64'({err_resp, err_last}), 64'd0);
      @(posedge clk);
      #1;

      // 6: asynchronous reset mid-burst with commands queued.
      clear_trace();
      push_cmd(32'h8000, 9'd64);
      push_cmd(32'h9000, 9'd64);
      push_cmd(32'hA000, 9'd64);
      t = 0;
      while (n_beats < 5 && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("t6_started", 64'(n_beats >= 5), 64'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      exp_ar_q.delete();
      exp_beat_q.delete();
      #1;
      check("t6_rst_arvalid", 64'(m_axi_arvalid), 64'd0);
      check("t6_rst_rready", 64'(m_axi_rready), 64'd0);
      check("t6_rst_out", 64'({out_valid, out_last}), 64'd0);
      check("t6_rst_out_data", out_data, 64'd0);
      check("t6_rst_ar", 64'({m_axi_araddr, m_axi_arlen}), 64'd0);
      check("t6_rst_cfg", 64'({config_ready, config_empty}), 64'd3);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_ar = 0;
      n_arvalid_cyc = 0;
      repeat (20) @(negedge clk);
      check("t6_empty", 64'(config_empty), 64'd1);
      check("t6_no_ar", 64'(n_arvalid_cyc), 64'd0);

      if (n_fail != 0) $display("%0d comparisons disagreed", n_fail);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
